// File: rtl/i2c_bus_dispatch.sv
// Bus-register command queue feeding NUM_CH I2C master channels.
// Define I2C_DISPATCH_TIMEOUT_EN to abort entries stalled for 65535 cycles.
module i2c_bus_dispatch #(
    parameter int         NUM_CH     = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [5:0] BUS_ADDR   = 6'h3d,
    parameter logic [7:0] CMD_BASE   = 8'h06
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        addr,
    input  logic [31:0]       data,
    input  logic              write,
    output logic              invalidate,
    output logic              busy,
    output logic              overflow,
    output logic              timeout,
    output logic [6:0]        cmd_address,
    output logic              cmd_start,
    output logic              cmd_read,
    output logic              cmd_write,
    output logic              cmd_write_multiple,
    output logic              cmd_stop,
    output logic [NUM_CH-1:0] cmd_valid,
    input  logic [NUM_CH-1:0] cmd_ready,
    output logic [7:0]        data_out,
    output logic              data_out_last,
    output logic [NUM_CH-1:0] data_out_valid,
    input  logic [NUM_CH-1:0] data_out_ready
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = PTRW + 1;
    localparam int EW   = CHW + 23;

    localparam logic [8:0] CODE_LO = {1'b0, CMD_BASE};
    localparam logic [8:0] CODE_HI = CODE_LO + 9'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA0,
        DATA1
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [EW-1:0]   mem_d [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [EW-1:0]   hold_q, hold_d;
    logic            overflow_q, overflow_d;

    logic [8:0]      code9;
    logic [7:0]      code_off;
    logic            hit;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [EW-1:0]   entry;

    logic [CHW-1:0]    hold_ch;
    logic [NUM_CH-1:0] ch_onehot;
    logic              cmd_hs;
    logic              dat_hs;
    logic              abort;
    logic              unused_ok;

    assign code9    = {1'b0, data[31:24]};
    assign code_off = data[31:24] - CMD_BASE;
    assign hit      = write && (addr == BUS_ADDR)
                      && (code9 >= CODE_LO)
                      && (code9 < CODE_HI);
    assign entry    = {code_off[CHW-1:0], data[22:0]};

    assign unused_ok = ^{data[23], code_off};

    assign full  = (count_q == CNTW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = hit && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign hold_ch   = hold_q[EW-1 -: CHW];
    assign ch_onehot = NUM_CH'(1) << hold_ch;

    assign cmd_hs = (state_q == CMD)
                    && |(cmd_ready & ch_onehot);
    assign dat_hs = ((state_q == DATA0) || (state_q == DATA1))
                    && |(data_out_ready & ch_onehot);

    assign invalidate = (addr == BUS_ADDR) && full;
    assign busy       = !empty || (state_q != IDLE);
    assign overflow   = overflow_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            hold_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Fullness is judged before the same-cycle pop.
        if (hit && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef I2C_DISPATCH_TIMEOUT_EN
    logic [15:0] timer_q, timer_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        timer_d   = '0;
        timeout_d = timeout_q;
        abort     = 1'b0;
        if ((state_q != IDLE) && !(cmd_hs || dat_hs)) begin
            if (timer_q == 16'hfffe) begin
                abort     = 1'b1;
                timeout_d = 1'b1;
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!empty) state_d = CMD;
            CMD:   if (cmd_hs) state_d = DATA0;
            DATA0: if (dat_hs) state_d = DATA1;
            DATA1: if (dat_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cmd_address        = '0;
        cmd_start          = 1'b0;
        cmd_read           = 1'b0;
        cmd_write          = 1'b0;
        cmd_write_multiple = 1'b0;
        cmd_stop           = 1'b0;
        cmd_valid          = '0;
        data_out           = '0;
        data_out_last      = 1'b0;
        data_out_valid     = '0;
        unique case (state_q)
            CMD: begin
                cmd_valid          = ch_onehot;
                cmd_address        = hold_q[22:16];
                cmd_start          = 1'b1;
                cmd_write_multiple = 1'b1;
                cmd_stop           = 1'b1;
            end
            DATA0: begin
                data_out_valid = ch_onehot;
                data_out       = hold_q[15:8];
            end
            DATA1: begin
                data_out_valid = ch_onehot;
                data_out       = hold_q[7:0];
                data_out_last  = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_bus_dispatch.sv
// Directed bench for i2c_bus_dispatch: decode table plus
// overflow, simultaneous push/pop and mid-transaction reset sequences.
module tb_i2c_bus_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        write;
    logic        invalidate;
    logic        busy;
    logic        overflow;
    logic        timeout;
    logic [6:0]  cmd_address;
    logic        cmd_start;
    logic        cmd_read;
    logic        cmd_write;
    logic        cmd_write_multiple;
    logic        cmd_stop;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_ready;
    logic [7:0]  data_out;
    logic        data_out_last;
    logic [1:0]  data_out_valid;
    logic [1:0]  data_out_ready;

    int total = 0;
    int bad   = 0;

    i2c_bus_dispatch #(
        .NUM_CH    (2),
        .FIFO_DEPTH(8),
        .BUS_ADDR  (6'h3d),
        .CMD_BASE  (8'h06)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .addr              (addr),
        .data              (data),
        .write             (write),
        .invalidate        (invalidate),
        .busy              (busy),
        .overflow          (overflow),
        .timeout           (timeout),
        .cmd_address       (cmd_address),
        .cmd_start         (cmd_start),
        .cmd_read          (cmd_read),
        .cmd_write         (cmd_write),
        .cmd_write_multiple(cmd_write_multiple),
        .cmd_stop          (cmd_stop),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .data_out          (data_out),
        .data_out_last     (data_out_last),
        .data_out_valid    (data_out_valid),
        .data_out_ready    (data_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        logic        hit;
        logic [1:0]  oh;
        logic [6:0]  ad;
        logic [7:0]  rg;
        logic [7:0]  vl;
    } vec_t;

    vec_t        vt [7];
    logic [31:0] w  [11];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a,
                      input logic [31:0] d);
        addr  = a;
        data  = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic consume(input logic [1:0] oh,
                           input logic [6:0] ad,
                           input logic [7:0] rg,
                           input logic [7:0] vl,
                           input string tag);
        int n = 0;
        while (cmd_valid == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'(oh));
        chk({tag, " cmd_address"}, 32'(cmd_address), 32'(ad));
        chk({tag, " cmd_flags"},
            32'({cmd_start, cmd_read, cmd_write,
                 cmd_write_multiple, cmd_stop}),
            32'(5'b10011));
        cmd_ready = ~oh;
        @(negedge clk);
        chk({tag, " cmd_hold"},
            32'({cmd_valid, cmd_address}), 32'({oh, ad}));
        cmd_ready = oh;
        @(negedge clk);
        cmd_ready = 2'b00;
        chk({tag, " cmd_drop"}, 32'(cmd_valid), 32'd0);
        chk({tag, " byte0"},
            32'({data_out_valid, data_out_last, data_out}),
            32'({oh, 1'b0, rg}));
        data_out_ready = ~oh;
        @(negedge clk);
        chk({tag, " byte0_hold"},
            32'({data_out_valid, data_out_last, data_out}),
            32'({oh, 1'b0, rg}));
        data_out_ready = oh;
        @(negedge clk);
        chk({tag, " byte1"},
            32'({data_out_valid, data_out_last, data_out}),
            32'({oh, 1'b1, vl}));
        @(negedge clk);
        data_out_ready = 2'b00;
        chk({tag, " done"}, 32'(data_out_valid), 32'd0);
    endtask

    function automatic logic [1:0] oh_of(input logic [31:0] d);
        return (d[31:24] == 8'h06) ? 2'b01 : 2'b10;
    endfunction

    task automatic consume_word(input logic [31:0] d,
                                input string tag);
        consume(oh_of(d), d[22:16], d[15:8], d[7:0], tag);
    endtask

    task automatic fill9();
        cmd_ready = 2'b00;
        addr      = 6'h3d;
        for (int i = 0; i < 9; i++) begin
            data  = w[i];
            write = 1'b1;
            @(negedge clk);
        end
        write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{6'h3d, 32'h076a1055, 1'b1, 2'b10,
                  7'h6a, 8'h10, 8'h55};
        vt[1] = '{6'h3d, 32'h06123456, 1'b1, 2'b01,
                  7'h12, 8'h34, 8'h56};
        vt[2] = '{6'h3d, 32'h06ffabcd, 1'b1, 2'b01,
                  7'h7f, 8'hab, 8'hcd};
        vt[3] = '{6'h3d, 32'h09123456, 1'b0, 2'b00,
                  7'h00, 8'h00, 8'h00};
        vt[4] = '{6'h3c, 32'h06123456, 1'b0, 2'b00,
                  7'h00, 8'h00, 8'h00};
        vt[5] = '{6'h3d, 32'h05123456, 1'b0, 2'b00,
                  7'h00, 8'h00, 8'h00};
        vt[6] = '{6'h3d, 32'h08123456, 1'b0, 2'b00,
                  7'h00, 8'h00, 8'h00};
        for (int i = 0; i < 11; i++) begin
            w[i] = {((i % 2) == 1) ? 8'h07 : 8'h06,
                    1'b0, 7'(7'h20 + i),
                    8'(i * 3 + 1), 8'(8'ha0 + i)};
        end

        rst            = 1'b0;
        addr           = 6'h00;
        data           = '0;
        write          = 1'b0;
        cmd_ready      = 2'b00;
        data_out_ready = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst data_valid", 32'(data_out_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);
        chk("rst bcast",
            32'({cmd_address, cmd_start, cmd_stop,
                 cmd_write_multiple, data_out, data_out_last}),
            32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            wr(vt[i].a, vt[i].d);
            addr = 6'h00;
            chk($sformatf("v%0d lat1", i), 32'(cmd_valid), 32'd0);
            if (vt[i].hit) begin
                @(negedge clk);
                chk($sformatf("v%0d lat2", i),
                    32'(cmd_valid), 32'(vt[i].oh));
                consume(vt[i].oh, vt[i].ad, vt[i].rg, vt[i].vl,
                        $sformatf("v%0d", i));
                chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
            end else begin
                chk($sformatf("v%0d busy0", i), 32'(busy), 32'd0);
                repeat (2) @(negedge clk);
                chk($sformatf("v%0d busy2", i), 32'(busy), 32'd0);
                chk($sformatf("v%0d cv", i), 32'(cmd_valid), 32'd0);
                chk($sformatf("v%0d ovf", i), 32'(overflow), 32'd0);
            end
        end

        do_reset();
        fill9();
        chk("ovf9 overflow", 32'(overflow), 32'd0);
        chk("ovf9 invalidate", 32'(invalidate), 32'd1);
        chk("ovf9 head", 32'(cmd_valid), 32'(oh_of(w[0])));
        addr = 6'h3c;
        #1;
        chk("ovf9 inv_other", 32'(invalidate), 32'd0);
        wr(6'h3d, w[9]);
        chk("ovf10 overflow", 32'(overflow), 32'd1);
        chk("ovf10 invalidate", 32'(invalidate), 32'd1);
        addr = 6'h00;
        for (int i = 0; i < 9; i++) begin
            consume_word(w[i], $sformatf("drain1_%0d", i));
        end
        @(negedge clk);
        chk("drain1 busy", 32'(busy), 32'd0);
        chk("drain1 cv", 32'(cmd_valid), 32'd0);

        do_reset();
        chk("run2 ovf_clr", 32'(overflow), 32'd0);
        fill9();
        consume_word(w[0], "pp0");
        wr(6'h3d, w[9]);
        chk("pp_full overflow", 32'(overflow), 32'd1);
        chk("pp_full inval", 32'(invalidate), 32'd0);
        consume_word(w[1], "pp1");
        wr(6'h3d, w[10]);
        chk("pp7 inval", 32'(invalidate), 32'd0);
        addr = 6'h00;
        for (int i = 2; i < 9; i++) begin
            consume_word(w[i], $sformatf("drain2_%0d", i));
        end
        consume_word(w[10], "drain2_10");
        @(negedge clk);
        chk("drain2 busy", 32'(busy), 32'd0);

        addr = 6'h3d;
        for (int i = 0; i < 4; i++) begin
            data  = w[i];
            write = 1'b1;
            @(negedge clk);
        end
        write     = 1'b0;
        addr      = 6'h00;
        cmd_ready = 2'b11;
        @(negedge clk);
        cmd_ready = 2'b00;
        chk("mid data0", 32'(data_out_valid), 32'(oh_of(w[0])));
        chk("mid ovf_pre", 32'(overflow), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid cv", 32'(cmd_valid), 32'd0);
        chk("mid dv", 32'(data_out_valid), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid overflow", 32'(overflow), 32'd0);
        chk("mid bcast",
            32'({cmd_address, data_out, data_out_last}), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post busy", 32'(busy), 32'd0);
        chk("post cv", 32'(cmd_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_bus_dispatch.md
I2C_BUS_DISPATCH -- requirements
Module: i2c_bus_dispatch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of I2C master channels served (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning command-queue entries (power of 2, 4..16).
REQ-003 SHALL have parameter BUS_ADDR, default 6'h3d, meaning the decoded bus register address.
REQ-004 SHALL have parameter CMD_BASE, default 8'h06, meaning the data[31:24] code of channel 0; channel k uses CMD_BASE+k.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is synchronous to it.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-low reset.
REQ-007 SHALL have port addr, input, 6, meaning the bus register address.
REQ-008 SHALL have port data, input, 32, meaning bus write data: [31:24] code, [22:16] device address, [15:8] register, [7:0] value.
REQ-009 SHALL have port write, input, 1, meaning a one-cycle bus write strobe.
REQ-010 SHALL have port invalidate, output, 1, meaning the write at BUS_ADDR cannot be accepted.
REQ-011 SHALL have port busy, output, 1, meaning the queue is non-empty or the FSM is not IDLE.
REQ-012 SHALL have port overflow, output, 1, meaning sticky flag: a matching write was dropped.
REQ-013 SHALL have ports cmd_address (7), cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop (1 each), outputs, broadcast to all channels.
REQ-014 SHALL have ports cmd_valid (NUM_CH) output and cmd_ready (NUM_CH) input, meaning per-channel command handshake.
REQ-015 SHALL have ports data_out (8), data_out_last (1) outputs broadcast, data_out_valid (NUM_CH) output, data_out_ready (NUM_CH) input.

Function
REQ-016 SHALL push {channel, data[22:0]} when write=1, addr=BUS_ADDR, data[31:24] in CMD_BASE..CMD_BASE+NUM_CH-1 and the queue is not full.
REQ-017 SHALL drop a matching write when full (fullness sampled before any same-cycle pop) and set overflow.
REQ-018 SHALL ignore writes with other addr or out-of-range code; no flag change.
REQ-019 SHALL drive invalidate = (addr==BUS_ADDR) & full, combinationally.
REQ-020 SHALL implement FSM IDLE -> CMD -> DATA0 -> DATA1 -> IDLE.
REQ-021 IDLE: when queue non-empty, pop head into a holding register and enter CMD next cycle; push at cycle N yields cmd_valid at N+2.
REQ-022 CMD: assert cmd_valid[ch] only, cmd_start=1, cmd_write_multiple=1, cmd_stop=1, cmd_read=cmd_write=0, cmd_address=held address; leave on cmd_ready[ch]&cmd_valid[ch].
REQ-023 DATA0: data_out=register byte, data_out_last=0, data_out_valid[ch]=1; leave on data_out_ready[ch].
REQ-024 DATA1: data_out=value byte, data_out_last=1; on data_out_ready[ch] return to IDLE.
REQ-025 SHALL hold all outputs stable while valid is asserted and ready is low; other channels' valid bits stay 0.
REQ-026 SHALL process entries strictly FIFO regardless of channel; simultaneous push and pop SHALL both take effect when not full.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1 distinguishes full from empty.

Reset
REQ-028 On rst=0 at a clk edge: FSM=IDLE, queue empty, overflow=0, all valid bits 0, broadcast outputs 0, busy=0 next cycle.
REQ-029 Reset mid-transaction SHALL abandon the held entry and drop all queued entries.

Configuration
REQ-030 With I2C_DISPATCH_TIMEOUT_EN defined: a 16-bit counter SHALL abort the current entry after 65535 consecutive cycles in CMD/DATA0/DATA1 without handshake, deassert valid, return to IDLE and set sticky output timeout; without it, no counter exists, FSM waits indefinitely and timeout is tied 0.

Verification
REQ-031 Write addr=3d data=0x07_6A_10_55, NUM_CH=2 -> cmd_valid=2'b10 two cycles later, address 0x6A, then bytes 0x10, 0x55 with last on second.
REQ-032 Nine writes with cmd_ready held 0, FIFO_DEPTH=8 -> first popped, eight queued, none dropped; a tenth write -> dropped, overflow=1, invalidate=1 while addr=3d.
REQ-033 Write with code 0x09 (NUM_CH=2) or addr=3c -> no queue change, busy stays 0.
REQ-034 Push on same cycle as pop with queue full -> push dropped, overflow=1; with queue at 7 -> both succeed, count stays 7.
REQ-035 Assert rst=0 during DATA0 with 3 queued -> next cycle all valid 0, busy 0, overflow 0.
REQ-036 With I2C_DISPATCH_TIMEOUT_EN, hold data_out_ready=0 in DATA0 -> after 65535 cycles valid drops, timeout=1, next entry dispatched.
